// File: rtl/seq_shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier_pkg
// Description : Shared state encoding and sizing helpers for the sequential
//               shift-and-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold the value N.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_add_multiplier_rca.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier_rca
// Description : Combinational N-bit ripple-carry adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carry;

    assign carry[0] = cin_i;

    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    endgenerate

    assign cout_o = carry[N];

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier
// Description : Multi-cycle unsigned N x N -> 2N shift-and-add multiplier
//               with start/busy/done handshake and registered product.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int CW = count_width(N);

    state_t          state_q, state_d;
    logic [N-1:0]    m_q,   m_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    q_q,   q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  p_q,   p_d;

    logic [N-1:0]    add_b;
    logic [N-1:0]    sum;
    logic            carry;

    // One conditional partial-product add per iteration.
    assign add_b = q_q[0] ? m_q : '0;

    seq_shift_add_multiplier_rca #(
        .N (N)
    ) u_rca (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shift {carry, sum, Q} right by one into {ACC, Q}.
                {acc_d, q_d} = {carry, sum, q_q[N-1:1]};
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    p_d     = {carry, sum, q_q[N-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign P    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_add_multiplier
// Description : Self-checking bench; N=4 directed table plus N=8 random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4;
    logic [7:0] p4;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .P(p4)
    );

    seq_shift_add_multiplier #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .P(p8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // One N=4 operation from IDLE; checks handshake timing and product.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int i;
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("busy_after_accept", busy4, 1);
        chk("done_after_accept", done4, 0);
        i = 1;
        while (!done4 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("done_seen", done4, 1);
        chk("latency", i, 5);
        chk("product", p4, exp);
        @(negedge clk);
        chk("done_single_pulse", done4, 0);
        chk("busy_cleared", busy4, 0);
        chk("product_hold", p4, exp);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        int          dones8;
        int          n;
        int          j;
        logic [7:0]  ra, rb;

        vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'd143};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
        vecs[3] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
        vecs[4] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};

        // Reset state
        #2;
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_p4", p4, 0);
        chk("rst_p8", p8, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_without_start", busy4, 0);

        for (int k = 0; k < 5; k++)
            run4(vecs[k].a, vecs[k].b, vecs[k].p);

        // Asynchronous reset in the middle of a multiply
        run4(4'd13, 4'd11, 8'd143);
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_busy", busy4, 0);
        chk("midrun_rst_done", done4, 0);
        chk("midrun_rst_p", p4, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_idle_busy", busy4, 0);
            chk("post_rst_idle_done", done4, 0);
        end

        // start during RUN must be ignored
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        j = 0;
        while (!done4 && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk("ignored_start_done", done4, 1);
        chk("ignored_start_p", p4, 42);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ignored_no_restart", busy4, 0);
            chk("ignored_hold_p", p4, 42);
        end

        // Back-to-back with start held high
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd6; start4 = 1'b1;
        j = 0;
        while (!done4 && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk("b2b_first_done", done4, 1);
        chk("b2b_first_p", p4, 30);
        a4 = 4'd9; b4 = 4'd9;
        j = 0;
        do begin
            @(negedge clk);
            j++;
        end while (!done4 && j < 40);
        chk("b2b_second_done", done4, 1);
        chk("b2b_spacing", j, 6);
        chk("b2b_second_p", p4, 81);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_idle", busy4, 0);

        // Randomised N=8 against plain multiplication; junk start while busy
        dones8 = 0;
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            a8 = ra; b8 = rb; start8 = 1'b1;
            @(negedge clk);
            exp_q.push_back(16'(ra) * 16'(rb));
            n = 1;
            while (!done8 && n < 40) begin
                start8 = 1'($urandom_range(0, 1));
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                @(negedge clk);
                n++;
            end
            start8 = 1'b0;
            if (!done8) begin
                chk("rand_timeout", 0, 1);
                break;
            end
            dones8++;
            chk("rand_latency", n, 9);
            chk("rand_product", p8, exp_q.pop_front());
            @(negedge clk);
            chk("rand_single_done", done8, 0);
        end
        chk("rand_done_count", dones8, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
